adpll_lock_detector: RTL and testbench
======================================

# adpll_lock_detector

Lock monitor that reads the ADPLL's phase-detector error and DCO control code and decides whether the loop is locked. It samples the error once per rising edge of the generated clock and runs a four-state lock FSM with separate acquire and release thresholds (hysteresis). On lock it captures the DCO control code. It sits beside the ADPLL top level in the `fpga_clk_i` domain and drives status LEDs and the control logic.

## Interface
Parameters:
- `PDET_WIDTH`, 8: width of the signed phase error input.
- `DCO_CC_WIDTH`, 9: width of the signed DCO control code input.
- `LOCK_TOL`, 2: maximum |error| counted as a good sample while acquiring.
- `UNLOCK_TOL`, 4: |error| above this is a bad sample while locked. Must be ≥ `LOCK_TOL`.
- `LOCK_COUNT`, 16: consecutive good samples required to declare lock (≥ 1).
- `UNLOCK_COUNT`, 4: consecutive bad samples required to declare loss of lock (≥ 1).
- `CNT_WIDTH`, 8: width of the sample counter. Must hold `max(LOCK_COUNT, UNLOCK_COUNT)`.

Ports:
- `fpga_clk_i` in 1: the single system clock; all logic is clocked on its rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: monitor enable; low forces UNLOCKED.
- `gen_clk_i` in 1: ADPLL generated clock, produced in the `fpga_clk_i` domain; used as data for edge detection only.
- `error_i` in `PDET_WIDTH`: signed phase error from the phase detector.
- `dco_cc_i` in `DCO_CC_WIDTH`: signed DCO control code from the loop filter.
- `locked_o` out 1: lock status, registered.
- `lock_lost_o` out 1: one-cycle pulse when lock is lost.
- `state_o` out 2: FSM state (0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER).
- `sample_cnt_o` out `CNT_WIDTH`: current good or bad sample count.
- `dco_cc_lock_o` out `DCO_CC_WIDTH`: `dco_cc_i` captured on lock declaration.

## Operation
- **Edge detect:** `gen_q <= gen_clk_i`. A sample strobe fires when `gen_clk_i & ~gen_q`; `error_i` is evaluated in that same cycle. `gen_q` resets to 1, so a `gen_clk_i` held high at reset release does not produce a strobe.
- **Magnitude:** |error| is computed at `PDET_WIDTH+1` bits, so the most negative error (-128 for the defaults) gives 128, not a wrapped value.
  - good = |e| ≤ `LOCK_TOL`.
  - bad = |e| > `UNLOCK_TOL`.
- **Counter:** saturates at its all-ones value and never wraps.
- **FSM transitions** (taken only on strobe cycles with `enable_i` = 1; otherwise state and counter hold):
  - UNLOCKED: good → ACQUIRE, cnt=1 (if `LOCK_COUNT`=1, go directly to LOCKED). Not good → stay, cnt=0.
  - ACQUIRE: good → cnt+1; when cnt+1 = `LOCK_COUNT` → LOCKED, cnt=0, capture `dco_cc_i`. Not good → UNLOCKED, cnt=0.
  - LOCKED: bad → HOLDOVER, cnt=1 (if `UNLOCK_COUNT`=1, go directly to UNLOCKED and pulse). Not bad → stay, cnt=0.
  - HOLDOVER: bad → cnt+1; when cnt+1 = `UNLOCK_COUNT` → UNLOCKED, cnt=0, pulse `lock_lost_o`. Not bad → LOCKED, cnt=0.
- **Outputs:**
  - `locked_o` = 1 in LOCKED and HOLDOVER. HOLDOVER does not drop lock.
  - `dco_cc_lock_o` holds its captured value until the next lock declaration.
- **`enable_i` low:** synchronously forces UNLOCKED with cnt=0 on the next clock, independent of strobe. If `locked_o` was 1, `lock_lost_o` pulses. `dco_cc_lock_o` is kept.
- **Reset (asynchronous, any time including mid-acquire):**
  - `state_o`=0, `sample_cnt_o`=0, `locked_o`=0, `lock_lost_o`=0, `dco_cc_lock_o`=0, `gen_q`=1.

## Timing
- Strobe and FSM decision happen in the same cycle. All outputs update on the next `fpga_clk_i` edge (1-cycle latency from the `gen_clk_i` rising edge).
- `locked_o` rises one cycle after the fpga cycle holding the `LOCK_COUNT`-th consecutive good strobe.
- `lock_lost_o` is high for exactly one cycle, aligned with `locked_o` falling.
- Samples arrive at most once per two fpga cycles (`gen_clk_i` high/low each last ≥ 1 cycle). No back-to-back strobes need handling.
- `error_i` and `dco_cc_i` are sampled as-is, since they are synchronous to `fpga_clk_i`.

## Test plan
- **Reset and idle:** reset low with `gen_clk_i`=1, then release → no strobe; all outputs 0 while `gen_clk_i` stays high.
- **Acquire:** error=+1 for 16 gen edges, `dco_cc_i`=-37 → `locked_o` rises 1 cycle after the 16th edge; `dco_cc_lock_o`=-37; `state_o`=2.
- **Broken acquire:** 10 good edges, then error=3, then 16 good edges → no lock at edge 10; lock after the final 16 only; cnt returns to 0 at the bad edge.
- **Hysteresis:** locked, then error=4 for 20 edges → stays locked, state 2. Then error=-5 for 3 edges, then 0 → HOLDOVER then back to LOCKED, `locked_o` never drops.
- **Loss:** locked, then error=-128 for 4 edges → `lock_lost_o` is a single-cycle pulse, `locked_o`=0, `state_o`=0; |-128| is treated as 128, not 0.
- **Enable/reset mid-operation:** drop `enable_i` in HOLDOVER → UNLOCKED next cycle with a `lock_lost_o` pulse. Assert `reset_i` during ACQUIRE (cnt=9) → immediate async clear, and reacquiring needs a full 16 good samples.

Source files
------------

// File: rtl/adpll_lock_detector.sv
// ADPLL lock monitor: samples the phase error on each generated-clock rising edge
// and runs a four-state lock FSM with separate acquire and release thresholds.
module adpll_lock_detector #(
    parameter int PDET_WIDTH   = 8,
    parameter int DCO_CC_WIDTH = 9,
    parameter int LOCK_TOL     = 2,
    parameter int UNLOCK_TOL   = 4,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    gen_clk_i,
    input  logic [PDET_WIDTH-1:0]   error_i,
    input  logic [DCO_CC_WIDTH-1:0] dco_cc_i,
    output logic                    locked_o,
    output logic                    lock_lost_o,
    output logic [1:0]              state_o,
    output logic [CNT_WIDTH-1:0]    sample_cnt_o,
    output logic [DCO_CC_WIDTH-1:0] dco_cc_lock_o
);

    localparam int MAG_W = PDET_WIDTH + 1;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [1:0] ST_HOLDOVER = 2'd3;

    localparam logic [MAG_W-1:0]     LOCK_TOL_C   = MAG_W'(LOCK_TOL);
    localparam logic [MAG_W-1:0]     UNLOCK_TOL_C = MAG_W'(UNLOCK_TOL);
    localparam logic [CNT_WIDTH-1:0] LOCK_CNT_C   = CNT_WIDTH'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_CNT_C = CNT_WIDTH'(UNLOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    logic                    gen_q, gen_d;
    logic [1:0]              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    locked_q, locked_d;
    logic                    lost_q, lost_d;
    logic [DCO_CC_WIDTH-1:0] dco_q, dco_d;

    logic                    strobe;
    logic [MAG_W-1:0]        err_ext;
    logic [MAG_W-1:0]        err_mag;
    logic                    good;
    logic                    bad;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic                    capture;

    assign gen_d  = gen_clk_i;
    assign strobe = gen_clk_i & ~gen_q;

    // One extra bit keeps |most negative error| from wrapping to itself.
    assign err_ext = {error_i[PDET_WIDTH-1], error_i};
    assign err_mag = err_ext[MAG_W-1] ? (~err_ext + MAG_W'(1)) : err_ext;
    assign good    = (err_mag <= LOCK_TOL_C);
    assign bad     = (err_mag >  UNLOCK_TOL_C);

    assign cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!enable_i) begin
            state_d = ST_UNLOCKED;
            cnt_d   = '0;
        end else if (strobe) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (good) begin
                        if (LOCK_CNT_C == CNT_ONE) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                            capture = 1'b1;
                        end else begin
                            state_d = ST_ACQUIRE;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (good) begin
                        if (cnt_inc == LOCK_CNT_C) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                            capture = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_UNLOCKED;
                        cnt_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (bad) begin
                        if (UNLOCK_CNT_C == CNT_ONE) begin
                            state_d = ST_UNLOCKED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_HOLDOVER;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_HOLDOVER: begin
                    if (bad) begin
                        if (cnt_inc == UNLOCK_CNT_C) begin
                            state_d = ST_UNLOCKED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Any exit from the locked pair, including a disable, is a loss of lock.
    always_comb begin
        locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLDOVER);
        lost_d   = locked_q & ~locked_d;
        dco_d    = capture ? dco_cc_i : dco_q;
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            gen_q    <= 1'b1;
            state_q  <= ST_UNLOCKED;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            dco_q    <= '0;
        end else begin
            gen_q    <= gen_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            dco_q    <= dco_d;
        end
    end

    assign locked_o      = locked_q;
    assign lock_lost_o   = lost_q;
    assign state_o       = state_q;
    assign sample_cnt_o  = cnt_q;
    assign dco_cc_lock_o = dco_q;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Directed bench for adpll_lock_detector with a reference model feeding
// a scoreboard queue that is checked against the DUT every cycle.
module tb_adpll_lock_detector;

    localparam int LC = 16;
    localparam int UC = 4;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic              gen_clk_i;
    logic signed [7:0] error_i;
    logic signed [8:0] dco_cc_i;
    logic              locked_o;
    logic              lock_lost_o;
    logic [1:0]        state_o;
    logic [7:0]        sample_cnt_o;
    logic [8:0]        dco_cc_lock_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] st;
        logic [7:0] cnt;
        logic       lk;
        logic       ll;
        logic [8:0] dco;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] m_state;
    logic [7:0] m_cnt;
    logic       m_locked;
    logic       m_lost;
    logic [8:0] m_dco;
    logic       m_genq;

    adpll_lock_detector dut (
        .fpga_clk_i    (clk),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .gen_clk_i     (gen_clk_i),
        .error_i       (error_i),
        .dco_cc_i      (dco_cc_i),
        .locked_o      (locked_o),
        .lock_lost_o   (lock_lost_o),
        .state_o       (state_o),
        .sample_cnt_o  (sample_cnt_o),
        .dco_cc_lock_o (dco_cc_lock_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 2'd0;
        m_cnt    = 8'd0;
        m_locked = 1'b0;
        m_lost   = 1'b0;
        m_dco    = 9'd0;
        m_genq   = 1'b1;
    endtask

    task automatic model_step(input logic g, input logic signed [7:0] e,
                              input logic signed [8:0] c, input logic en);
        int  mag;
        bit  strobe;
        bit  good;
        bit  bad;
        mag    = (e < 0) ? -int'(e) : int'(e);
        good   = (mag <= 2);
        bad    = (mag > 4);
        strobe = g && !m_genq;
        m_genq = g;
        m_lost = 1'b0;
        if (!en) begin
            m_lost  = m_locked;
            m_state = 2'd0;
            m_cnt   = 8'd0;
        end else if (strobe) begin
            case (m_state)
                2'd0: if (good) begin m_state = 2'd1; m_cnt = 8'd1; end
                      else m_cnt = 8'd0;
                2'd1: if (!good) begin m_state = 2'd0; m_cnt = 8'd0; end
                      else if (int'(m_cnt) + 1 == LC) begin
                          m_state = 2'd2; m_cnt = 8'd0; m_dco = c;
                      end else m_cnt = m_cnt + 8'd1;
                2'd2: if (bad) begin m_state = 2'd3; m_cnt = 8'd1; end
                      else m_cnt = 8'd0;
                default: if (!bad) begin m_state = 2'd2; m_cnt = 8'd0; end
                      else if (int'(m_cnt) + 1 == UC) begin
                          m_state = 2'd0; m_cnt = 8'd0; m_lost = 1'b1;
                      end else m_cnt = m_cnt + 8'd1;
            endcase
        end
        m_locked = (m_state == 2'd2) || (m_state == 2'd3);
    endtask

    // Called at a falling edge: drive, predict, cross one rising edge, compare.
    task automatic step(input logic g, input logic signed [7:0] e,
                        input logic signed [8:0] c, input logic en);
        exp_t x;
        gen_clk_i = g;
        error_i   = e;
        dco_cc_i  = c;
        enable_i  = en;
        model_step(g, e, c, en);
        x.st  = m_state;
        x.cnt = m_cnt;
        x.lk  = m_locked;
        x.ll  = m_lost;
        x.dco = m_dco;
        exp_q.push_back(x);
        @(negedge clk);
        x = exp_q.pop_front();
        chk("state", 32'(state_o), 32'(x.st));
        chk("cnt", 32'(sample_cnt_o), 32'(x.cnt));
        chk("locked", 32'(locked_o), 32'(x.lk));
        chk("lock_lost", 32'(lock_lost_o), 32'(x.ll));
        chk("dco_lock", 32'(dco_cc_lock_o), 32'(x.dco));
    endtask

    task automatic sample(input logic signed [7:0] e,
                          input logic signed [8:0] c);
        step(1'b0, e, c, 1'b1);
        step(1'b1, e, c, 1'b1);
    endtask

    initial begin
        reset_i   = 1'b0;
        enable_i  = 1'b1;
        gen_clk_i = 1'b1;
        error_i   = '0;
        dco_cc_i  = '0;
        model_reset();
        #12;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_dco", 32'(dco_cc_lock_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 8'sd0, 9'sd0, 1'b1);
        chk("idle_cnt", 32'(sample_cnt_o), 32'd0);

        for (int i = 0; i < 15; i++) sample(8'sd1, -9'sd37);
        chk("acq15_state", 32'(state_o), 32'd1);
        chk("acq15_cnt", 32'(sample_cnt_o), 32'd15);
        chk("acq15_locked", 32'(locked_o), 32'd0);
        sample(8'sd1, -9'sd37);
        chk("acq_locked", 32'(locked_o), 32'd1);
        chk("acq_state", 32'(state_o), 32'd2);
        chk("acq_dco", 32'(dco_cc_lock_o), 32'h1DB);

        for (int i = 0; i < 20; i++) sample(8'sd4, 9'sd5);
        chk("hyst_state", 32'(state_o), 32'd2);
        for (int i = 0; i < 3; i++) sample(-8'sd5, 9'sd5);
        chk("hold_state", 32'(state_o), 32'd3);
        chk("hold_cnt", 32'(sample_cnt_o), 32'd3);
        chk("hold_locked", 32'(locked_o), 32'd1);
        sample(8'sd0, 9'sd5);
        chk("relock_state", 32'(state_o), 32'd2);
        chk("relock_dco", 32'(dco_cc_lock_o), 32'h1DB);

        for (int i = 0; i < 3; i++) sample(-8'sd128, 9'sd0);
        chk("loss3_locked", 32'(locked_o), 32'd1);
        sample(-8'sd128, 9'sd0);
        chk("loss_pulse", 32'(lock_lost_o), 32'd1);
        chk("loss_locked", 32'(locked_o), 32'd0);
        chk("loss_state", 32'(state_o), 32'd0);
        step(1'b1, -8'sd128, 9'sd0, 1'b1);
        chk("loss_pulse_end", 32'(lock_lost_o), 32'd0);

        for (int i = 0; i < 10; i++) sample(-8'sd2, 9'sd100);
        chk("brk10_cnt", 32'(sample_cnt_o), 32'd10);
        sample(8'sd3, 9'sd100);
        chk("brk_cnt", 32'(sample_cnt_o), 32'd0);
        chk("brk_state", 32'(state_o), 32'd0);
        for (int i = 0; i < 15; i++) sample(8'sd2, 9'sd100);
        chk("brk15_locked", 32'(locked_o), 32'd0);
        sample(8'sd2, 9'sd100);
        chk("brk_locked", 32'(locked_o), 32'd1);
        chk("brk_dco", 32'(dco_cc_lock_o), 32'd100);

        sample(8'sd5, 9'sd0);
        sample(8'sd5, 9'sd0);
        chk("en_hold", 32'(state_o), 32'd3);
        step(1'b1, 8'sd5, 9'sd0, 1'b0);
        chk("en_state", 32'(state_o), 32'd0);
        chk("en_pulse", 32'(lock_lost_o), 32'd1);
        step(1'b1, 8'sd5, 9'sd0, 1'b1);
        chk("en_pulse_end", 32'(lock_lost_o), 32'd0);
        chk("en_dco_kept", 32'(dco_cc_lock_o), 32'd100);

        for (int i = 0; i < 9; i++) sample(8'sd0, 9'sd50);
        chk("mid_cnt", 32'(sample_cnt_o), 32'd9);
        #2 reset_i = 1'b0;
        #1;
        chk("async_state", 32'(state_o), 32'd0);
        chk("async_cnt", 32'(sample_cnt_o), 32'd0);
        chk("async_dco", 32'(dco_cc_lock_o), 32'd0);
        model_reset();
        @(negedge clk);
        reset_i = 1'b1;
        for (int i = 0; i < 15; i++) sample(8'sd0, 9'sd50);
        chk("re15_locked", 32'(locked_o), 32'd0);
        sample(8'sd0, 9'sd50);
        chk("re_locked", 32'(locked_o), 32'd1);
        chk("re_dco", 32'(dco_cc_lock_o), 32'd50);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
